// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN layer sequencer: FSM state encoding,
// layer index assignments and the default number of sequenced layer engines.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

  localparam int L_CONV1 = 0;
  localparam int L_POOL1 = 1;
  localparam int L_CONV2 = 2;
  localparam int L_POOL2 = 3;
  localparam int L_FC    = 4;

  localparam int N_LAYER_DEF = 5;

endpackage

// File: rtl/cnn_wdog.sv
// Per-layer watchdog: clear/enable counter that saturates at all-ones and
// flags expiry while saturated. Only instantiated when CNN_LAYER_WDOG_EN is set.
module cnn_wdog #(
  parameter int WDOG_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + WDOG_W'(1);
    end
  end

  assign expired = &count;

endmodule

// File: rtl/cnn_layer_seq.sv
// Layer sequencer: starts conv1..fc in order with one-cycle pulses, waits for
// each done, then holds result_valid until acknowledged. Optional per-layer
// watchdog and ERR state are enabled by defining CNN_LAYER_WDOG_EN.
module cnn_layer_seq
  import cnn_pkg::*;
#(
  parameter int N_LAYER = N_LAYER_DEF,
  parameter int IDX_W   = 3,
  parameter int WDOG_W  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_LAYER-1:0] layer_done,
  input  logic               result_ack,
  output logic [N_LAYER-1:0] layer_start,
  output logic [IDX_W-1:0]   layer_idx,
  output logic               busy,
  output logic               result_valid,
  output logic               error,
  output logic [15:0]        frame_cnt
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(L_CONV1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_LAYER - 1);

  state_e           state;
  state_e           state_next;
  logic [IDX_W-1:0] idx_next;
  logic             frame_inc;
  logic             done_hit;

  // Only the current layer's completion bit is ever looked at.
  assign done_hit = layer_done[layer_idx];

`ifdef CNN_LAYER_WDOG_EN
  logic wdog_expired;

  cnn_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == START),
    .en      (state == WAIT),
    .expired (wdog_expired)
  );
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = layer_idx;
    frame_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = START;
          idx_next   = FIRST_IDX;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        // A done arriving together with watchdog expiry still advances.
        if (done_hit) begin
          if (layer_idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            state_next = START;
            idx_next   = layer_idx + IDX_W'(1);
          end
        end
`ifdef CNN_LAYER_WDOG_EN
        else if (wdog_expired) begin
          state_next = ERR;
        end
`endif
      end
      DONE: begin
        // result_valid is already high whenever we sit in DONE, so an ack on
        // the entry edge is naturally ignored.
        if (result_ack) begin
          state_next = IDLE;
          frame_inc  = 1'b1;
        end
      end
`ifdef CNN_LAYER_WDOG_EN
      ERR: begin
        if (start) begin
          state_next = START;
          idx_next   = FIRST_IDX;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      layer_start  <= '0;
      layer_idx    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_next;
      layer_idx    <= idx_next;
      layer_start  <= (state_next == START) ? (N_LAYER'(1) << idx_next) : '0;
      busy         <= (state_next == START) || (state_next == WAIT) ||
                      (state_next == DONE);
      result_valid <= (state_next == DONE);
      if (frame_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

`ifdef CNN_LAYER_WDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error <= 1'b0;
    end else begin
      error <= (state_next == ERR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/cnn_layer_seq.md
# cnn_layer_seq

Top-level layer sequencer for the CNN accelerator, directly downstream of the power-on reset generator. After reset release it waits for an image-ready request. It then starts each layer engine in order (conv1, pool1, conv2, pool2, fc) with a one-cycle start pulse and waits for each layer's done before starting the next. Finally it presents a result-valid handshake to the output stage, with an optional per-layer watchdog.

## Interface
- N_LAYER, 5, number of layer engines sequenced; index 0 runs first.
- IDX_W, 3, width of layer_idx; must satisfy 2^IDX_W >= N_LAYER.
- WDOG_W, 20, watchdog counter width; timeout after 2^WDOG_W-1 cycles in one layer.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low; driven from the reset generator output through the top-level inversion.
- start  in  1  image ready; sampled only in IDLE and ERR.
- layer_done  in  N_LAYER  per-layer completion pulse; only bit layer_idx is honoured, only in WAIT.
- result_ack  in  1  output stage has taken the result.
- layer_start  out  N_LAYER  one-hot single-cycle start pulse.
- layer_idx  out  IDX_W  index of the current/last started layer.
- busy  out  1  high in START, WAIT, DONE.
- result_valid  out  1  final result available; held until acknowledged.
- error  out  1  watchdog expired; sticky.
- frame_cnt  out  16  count of completed, acknowledged frames.

## Operation
- All outputs are registered. Reset values: layer_start=0, layer_idx=0, busy=0, result_valid=0, error=0, frame_cnt=0, state=IDLE, watchdog=0.
- States:
  - IDLE: start=1 -> START, idx=0.
  - START: layer_start[idx]=1 for exactly one cycle, watchdog cleared -> WAIT.
  - WAIT: layer_done[idx]=1 and idx<N_LAYER-1 -> idx+1, START. layer_done[idx]=1 and idx=N_LAYER-1 -> DONE. Watchdog at all-ones -> ERR.
  - DONE: result_valid=1. result_ack=1 -> IDLE and frame_cnt+1.
  - ERR: error=1, busy=0, layer_idx frozen at the failing layer. start=1 -> clear error, idx=0, START.
- start outside IDLE/ERR is ignored; no queuing.
- layer_done bits other than idx are ignored. Any done seen in START, DONE, IDLE or ERR is ignored.
- layer_done[idx] and watchdog expiry in the same cycle: done wins.
- result_ack is honoured only while result_valid is already 1. An ack in the same cycle DONE is entered is ignored.
- frame_cnt wraps 16'hFFFF -> 0. Errored frames are not counted.
- rst low mid-frame: everything returns immediately to reset values. Layer engines are reset by the same net, so no abort pulse is sent.

## Timing
- start sampled high at edge t -> layer_start[0] high during cycle t+1 only.
- layer_done[i] sampled high at edge u (in WAIT) -> layer_start[i+1] high during cycle u+1.
- Minimum per-layer overhead is 2 cycles: the START cycle plus at least one WAIT cycle.
- Last layer's done at edge u -> result_valid high from cycle u+1.
- result_ack sampled at edge v -> result_valid low, busy low, and frame_cnt incremented from cycle v+1.
- Watchdog counts WAIT cycles. error rises one cycle after the count reaches 2^WDOG_W-1.

## Configuration
- CNN_LAYER_WDOG_EN defined: watchdog counter, ERR state and error output are present as described.
- Not defined: no watchdog logic. WAIT waits indefinitely, error is tied 0, ERR is unreachable, and start is sampled in IDLE only.

## Structure
- Shared package cnn_pkg holds:
  - the state enum (IDLE, START, WAIT, DONE, ERR);
  - layer index constants L_CONV1=0, L_POOL1=1, L_CONV2=2, L_POOL2=3, L_FC=4;
  - the default N_LAYER.
- One sub-module, cnn_wdog: clear/enable counter with WDOG_W-bit saturating count and an expired flag. It is instantiated only under CNN_LAYER_WDOG_EN.

## Test plan
- Nominal frame: rst released, start pulse, each layer_done returned 3 cycles after its start. Expect:
  - layer_start sequence 00001, 00010, 00100, 01000, 10000, each exactly 1 cycle wide;
  - result_valid rises 1 cycle after the done[4] edge;
  - ack -> frame_cnt=1, busy=0.
- Wrong/early done (done[2] driven while idx=0; done[0] during the START cycle): ignored, FSM stays in WAIT idx=0. Only a done[0] in WAIT advances.
- Watchdog with WDOG_W=4 and no done for layer 2: error=1 and layer_idx=2 after 15 WAIT cycles plus 1. Then start -> error=0, layer_start[0] pulses, frame_cnt unchanged.
- Back-to-back frames: start held high continuously, ack given the cycle after result_valid, 3 frames run. Expect frame_cnt=3 and start not honoured during busy.
- Mid-frame reset: rst low while idx=3 in WAIT. Expect all outputs at reset values the same cycle (asynchronous), frame_cnt=0, and no layer_start after release until start.
- Wrap: frame_cnt preloaded via force to 16'hFFFF, one frame completed -> frame_cnt=0.
